mux_arbiter_2to1: RTL and testbench
===================================

Name: mux_arbiter_2to1

Overview:
Round-robin arbiter that shares one 2-to-1 data mux, and therefore one downstream bus port (e.g. the L1-to-L2 request path), between two requesters. It sequences ownership with a req/gnt handshake, bounds each tenure with a hold counter, and drives the mux select so that only the owner's data reaches the shared output. It instantiates mux_2to1 as its datapath.

Parameters:
DATA_WIDTH, 8, width of requester data and of the shared output.
MAX_HOLD, 4, maximum consecutive granted cycles while the other requester waits; legal range is 1 or more.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
req0  input  1  requester 0 wants the bus; held high for the whole tenure.
req1  input  1  requester 1 wants the bus; held high for the whole tenure.
wdata0  input  DATA_WIDTH  requester 0 data.
wdata1  input  DATA_WIDTH  requester 1 data.
gnt0  output  1  requester 0 owns the bus (registered).
gnt1  output  1  requester 1 owns the bus (registered).
sel  output  1  mux select (registered); 0 = requester 0, 1 = requester 1.
dout  output  DATA_WIDTH  shared bus data; combinational through the mux from sel.
dout_valid  output  1  high when (gnt0 & req0) | (gnt1 & req1).

Behaviour:
- Reset values (synchronous, rst=1 at an edge):
  - gnt0=0, gnt1=0, sel=0, state=IDLE, hold_cnt=0.
  - last_owner=1, so requester 0 wins the first tie.
  - rst overrides all other inputs, including mid-tenure; grants drop on the edge after rst is sampled.
- States and transitions:
  - IDLE:
    - Only req0 -> GRANT0; only req1 -> GRANT1.
    - Both -> grant the requester that is not last_owner.
    - Neither -> stay in IDLE.
  - GRANT0: gnt0=1, sel=0. Release conditions:
    - req0 low and req1 high -> GRANT1.
    - req0 low and req1 low -> IDLE.
    - req0 high, req1 high, hold_cnt == MAX_HOLD-1 -> forced handoff to GRANT1.
    - Otherwise stay in GRANT0.
  - GRANT1: symmetric to GRANT0.
- Handshake:
  - Grant is asserted 1 cycle after req is first sampled high; there is no combinational req->gnt path.
  - Handoff is direct, with no idle bubble: gnt0 falls and gnt1 rises on the same edge.
  - At most one of gnt0/gnt1 is ever high (checked by assertion).
- sel:
  - Updated on the same edge as the grant.
  - Holds its last value in IDLE.
  - Because of this, dout shows the last owner's data when idle, and dout_valid=0 there.
- Hold counter:
  - Width is clog2(MAX_HOLD+1).
  - Cleared on entry to any GRANT state and in IDLE.
  - Increments each cycle spent in a GRANT state.
  - Saturates at MAX_HOLD-1 while the other requester is idle, so the owner keeps the bus indefinitely; it is preempted on the first cycle the other requester goes high.
  - MAX_HOLD=1 alternates every cycle under continuous contention.
- last_owner: updated to the new owner on every entry to a GRANT state.
- Preemption: a requester whose grant is revoked by timeout must keep req high and is re-granted by round-robin. Data accepted on a cycle is exactly dout during dout_valid=1.
- Requester dropping req in the same cycle as a timeout: treated as a normal release; the other requester is granted, same resulting state.

Decomposition:
- Shared package / define file: state encodings IDLE=2'b00, GRANT0=2'b01, GRANT1=2'b10; owner codes.
- Sub-module: mux_2to1 (DATA_WIDTH passed through) with sel->sel, din1<-wdata0, din2<-wdata1, dout->dout.
- All FSM, counter and round-robin logic stays in this module.

Test Plan:
1. Reset then idle: rst high 2 cycles, no req -> gnt0=gnt1=0, sel=0, dout_valid=0, dout=wdata0.
2. Single requester: req0=1 at cycle 2, wdata0=8'hA0 -> gnt0=1, sel=0 from cycle 3; dout=8'hA0, dout_valid=1; req0 low at cycle 6 -> gnt0=0 at cycle 7.
3. First tie after reset: req0=req1=1 together, MAX_HOLD=4 -> gnt0 for 4 cycles, then gnt1 for 4 cycles, alternating; sel toggles on handoff edges; never both grants high.
4. Voluntary handoff: gnt1 active with wdata1=8'hBB; req1 drops while req0=1, wdata0=8'hCC -> next edge gnt1=0, gnt0=1, dout=8'hCC with no idle cycle.
5. Saturation: req0 held 10 cycles alone -> gnt0 stays high throughout; req1 rises at cycle 10 -> gnt1 granted at cycle 11.
6. Reset mid-tenure: gnt1=1, sel=1, rst pulsed for 1 cycle -> next edge gnt1=0, sel=0; with both reqs still high, gnt0 wins after reset.

Source files
------------

// File: rtl/mux_arbiter_2to1_pkg.sv
// mux_arbiter_2to1_pkg: shared state encodings and owner codes for the 2-to-1 bus arbiter
package mux_arbiter_2to1_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT0 = 2'b01,
    GRANT1 = 2'b10
  } state_t;
  localparam logic OWNER0 = 1'b0;
  localparam logic OWNER1 = 1'b1;
  function automatic logic is_grant(input state_t s);
    return s == GRANT0 || s == GRANT1;
  endfunction
endpackage

// File: rtl/mux_2to1.sv
// mux_2to1: shared datapath select, 0 picks din1 and 1 picks din2
module mux_2to1 #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  sel,
  input  logic [DATA_WIDTH-1:0] din1,
  input  logic [DATA_WIDTH-1:0] din2,
  output logic [DATA_WIDTH-1:0] dout
);
  assign dout = sel ? din2 : din1;
endmodule

// File: rtl/mux_arbiter_2to1.sv
// mux_arbiter_2to1: round-robin req/gnt arbiter with bounded tenure driving a shared 2-to-1 data mux
module mux_arbiter_2to1
  import mux_arbiter_2to1_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_HOLD   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  sel,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid
);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  state_t        state;
  state_t        nxt;
  logic [HW-1:0] hold_cnt;
  logic          last_owner;
  logic          hold_done;
  logic          entering;
  assign hold_done = hold_cnt == HOLD_LAST;
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:    nxt = (req0 && req1) ? (last_owner == OWNER1 ? GRANT0 : GRANT1) :
                     req0 ? GRANT0 : req1 ? GRANT1 : IDLE;
      GRANT0:  nxt = !req0 ? (req1 ? GRANT1 : IDLE) : (req1 && hold_done) ? GRANT1 : GRANT0;
      GRANT1:  nxt = !req1 ? (req0 ? GRANT0 : IDLE) : (req0 && hold_done) ? GRANT0 : GRANT1;
      default: nxt = IDLE;
    endcase
  end
  assign entering = is_grant(nxt) && nxt != state;
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      sel        <= 1'b0;
      hold_cnt   <= '0;
      last_owner <= OWNER1;
    end else begin
      state      <= nxt;
      gnt0       <= nxt == GRANT0;
      gnt1       <= nxt == GRANT1;
      sel        <= nxt == GRANT0 ? 1'b0 : nxt == GRANT1 ? 1'b1 : sel;
      hold_cnt   <= (nxt == IDLE || entering) ? '0 : hold_done ? hold_cnt : hold_cnt + 1'b1;
      last_owner <= entering ? (nxt == GRANT1 ? OWNER1 : OWNER0) : last_owner;
    end
  end
  assign dout_valid = (gnt0 && req0) || (gnt1 && req1);
  mux_2to1 #(.DATA_WIDTH(DATA_WIDTH)) u_mux (
    .sel  (sel),
    .din1 (wdata0),
    .din2 (wdata1),
    .dout (dout)
  );
  assert property (@(posedge clk) disable iff (rst) !(gnt0 && gnt1));
endmodule

// File: tb/tb_mux_arbiter_2to1.sv
// tb_mux_arbiter_2to1: directed vectors with hand-computed expectations for the 2-to-1 bus arbiter
module tb_mux_arbiter_2to1;
  logic       clk = 1'b0;
  logic       rst;
  logic       req0;
  logic       req1;
  logic [7:0] wdata0;
  logic [7:0] wdata1;
  logic       gnt0;
  logic       gnt1;
  logic       sel;
  logic [7:0] dout;
  logic       dout_valid;
  int         n_cmp = 0;
  int         n_bad = 0;
  mux_arbiter_2to1 #(.DATA_WIDTH(8), .MAX_HOLD(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0       (req0),
    .req1       (req1),
    .wdata0     (wdata0),
    .wdata1     (wdata1),
    .gnt0       (gnt0),
    .gnt1       (gnt1),
    .sel        (sel),
    .dout       (dout),
    .dout_valid (dout_valid)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic chk_own(input string tag, input logic g0, input logic g1, input logic s);
    chk({tag, "_gnt0"}, gnt0, g0);
    chk({tag, "_gnt1"}, gnt1, g1);
    chk({tag, "_sel"}, sel, s);
  endtask
  initial begin
    rst = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    wdata0 = 8'h11;
    wdata1 = 8'h22;
    tick();
    tick();
    chk_own("rst", 1'b0, 1'b0, 1'b0);
    chk("rst_valid", dout_valid, 1'b0);
    chk("rst_dout", dout, 8'h11);
    rst = 1'b0;
    tick();
    chk_own("idle", 1'b0, 1'b0, 1'b0);
    wdata0 = 8'hA0;
    req0 = 1'b1;
    tick();
    chk_own("single", 1'b1, 1'b0, 1'b0);
    chk("single_dout", dout, 8'hA0);
    chk("single_valid", dout_valid, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("single_hold", gnt0, 1'b1);
    end
    req0 = 1'b0;
    tick();
    chk_own("single_rel", 1'b0, 1'b0, 1'b0);
    chk("single_rel_valid", dout_valid, 1'b0);
    chk("idle_dout", dout, 8'hA0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wdata0 = 8'hCC;
    wdata1 = 8'hBB;
    req0 = 1'b1;
    req1 = 1'b1;
    for (int k = 0; k < 14; k++) begin
      tick();
      chk_own("tie", ((k / 4) % 2) == 0, ((k / 4) % 2) == 1, ((k / 4) % 2) == 1);
      chk("tie_valid", dout_valid, 1'b1);
    end
    chk("tie_dout1", dout, 8'hBB);
    req1 = 1'b0;
    tick();
    chk_own("vol", 1'b1, 1'b0, 1'b0);
    chk("vol_dout", dout, 8'hCC);
    chk("vol_valid", dout_valid, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("sat_gnt0", gnt0, 1'b1);
    end
    req1 = 1'b1;
    tick();
    chk_own("preempt", 1'b0, 1'b1, 1'b1);
    chk("preempt_dout", dout, 8'hBB);
    rst = 1'b1;
    tick();
    chk_own("midrst", 1'b0, 1'b0, 1'b0);
    chk("midrst_valid", dout_valid, 1'b0);
    rst = 1'b0;
    tick();
    chk_own("postrst", 1'b1, 1'b0, 1'b0);
    chk("postrst_dout", dout, 8'hCC);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
